dram_request_arbiter: RTL and testbench

Shares the single DRAM controller application port between NUM_REQ independent requesters, for example the sample-loader write stream, the audio read-address stream and a future read client. It runs in the DRAM controller UI clock domain and sits between the per-client CDC FIFOs and the controller app interface. It round-robins command issue, tracks outstanding reads in order, and routes returned read data back to the client that issued each read.

---
 rtl/dram_arb_pkg.sv | 23 ++
 rtl/dram_tag_fifo.sv | 65 ++++++
 rtl/dram_request_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_dram_request_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arb_pkg.sv
// Shared definitions for the DRAM request arbiter.
// Contents:
//   ADDR_W_DEF, DATA_W_DEF : default address / data widths
//   CMD_WRITE, CMD_READ    : controller app_cmd encodings
//   req_idx_t              : requester index, sized for the largest supported NUM_REQ
//   arb_state_t            : arbiter FSM state
package dram_arb_pkg;

  localparam int ADDR_W_DEF  = 24;
  localparam int DATA_W_DEF  = 128;
  localparam int MAX_NUM_REQ = 4;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef logic [$clog2(MAX_NUM_REQ)-1:0] req_idx_t;

  typedef enum logic {
    ST_ARB   = 1'b0,  // no command held
    ST_ISSUE = 1'b1   // command held on mem_* outputs
  } arb_state_t;

endpackage

// File: rtl/dram_tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each read that the
// controller has accepted but not yet returned.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   push_i         : write push_data_i (ignored when full unless popping too)
//   push_data_i    : requester index of the accepted read
//   pop_i          : drop the head entry (ignored when empty)
//   head_o         : current head entry
//   count_o        : occupancy, 0..DEPTH
//   empty_o/full_o : occupancy flags
module dram_tag_fifo
  import dram_arb_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  req_idx_t         push_data_i,
  input  logic             pop_i,
  output req_idx_t         head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  req_idx_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A simultaneous pop frees the slot, so a push into a full FIFO is legal then.
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage needs no reset: entries are only read when count_q says they are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dram_request_arbiter.sv
// Round-robin arbiter sharing one DRAM controller app port among NUM_REQ
// requesters, with in-order routing of read data back to the issuing client.
// Handshake: a requester presents req_valid with a stable payload; req_ready
// pulses for exactly the cycle in which the payload is captured, after which
// the requester may present its next command. Responses are never
// backpressured.
// Ports:
//   clk_dram_ctrl, rst_dram_ctrl : UI clock, asynchronous active-high reset
//   en                            : permit new grants
//   req_valid/write/addr/wdata    : per-client command inputs
//   req_ready                     : one-hot capture pulse
//   rsp_valid, rsp_data           : one-hot read-return strobe and shared data
//   mem_*                         : controller app interface
//   rd_outstanding                : reads accepted by the controller, not yet returned
//   err_orphan_rd                 : sticky, read data arrived with no owner
//   dbg_state                     : arbiter FSM state
module dram_request_arbiter
  import dram_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 3,
  parameter  int ADDR_W     = ADDR_W_DEF,
  parameter  int DATA_W     = DATA_W_DEF,
  parameter  int MAX_RD_OUT = 16,
  localparam int CNT_W      = $clog2(MAX_RD_OUT) + 1
) (
  input  logic                           clk_dram_ctrl,
  input  logic                           rst_dram_ctrl,
  input  logic                           en,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_W-1:0]              rsp_data,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic                           mem_en,
  output logic                           mem_write,
  output logic [DATA_W-1:0]              mem_wdata,
  output logic                           mem_wren,
  input  logic                           mem_rdy,
  input  logic                           mem_wdf_rdy,
  input  logic [DATA_W-1:0]              mem_rd_data,
  input  logic                           mem_rd_valid,
  output logic [CNT_W-1:0]               rd_outstanding,
  output logic                           err_orphan_rd,
  output arb_state_t                     dbg_state
);

  localparam logic [CNT_W:0] RD_LIMIT = (CNT_W+1)'(MAX_RD_OUT);

  arb_state_t           state_q;
  req_idx_t             ptr_q;
  req_idx_t             held_idx_q;
  logic                 mem_en_q;
  logic [2:0]           cmd_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic [DATA_W-1:0]    mem_wdata_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [DATA_W-1:0]    rsp_data_q;
  logic                 err_q;

  logic                 accept;
  logic                 held_read;
  logic                 grant;
  logic                 read_room;
  logic [CNT_W:0]       rd_load;
  logic [NUM_REQ-1:0]   elig;
  req_idx_t             grant_idx;
  req_idx_t             tag_head;
  logic                 tag_empty;
  logic                 tag_full;

  // First eligible client after ptr, wrapping; ptr itself is checked last.
  function automatic req_idx_t rr_pick(input logic [NUM_REQ-1:0] e, input req_idx_t ptr);
    req_idx_t pick;
    logic     found;
    int       idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && e[req_idx_t'(idx)]) begin
        pick  = req_idx_t'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign mem_en    = mem_en_q;
  assign mem_write = (cmd_q == CMD_WRITE);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  // Write data travels with the command, so the data strobe mirrors the command strobe.
  assign mem_wren  = mem_en_q & mem_write;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign err_orphan_rd = err_q;
  assign dbg_state = state_q;

  assign accept    = mem_en_q & mem_rdy & (~mem_write | mem_wdf_rdy);
  // A held read has no tag yet but will need one, so it is reserved here.
  assign held_read = mem_en_q & ~mem_write;
  assign rd_load   = {1'b0, rd_outstanding} + {{CNT_W{1'b0}}, held_read};
  assign read_room = (rd_load < RD_LIMIT) & ~tag_full;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i] & en & (req_write[i] | read_room);
    end
  end

  // A new grant may replace the held command only in the cycle it is accepted.
  assign grant     = ((state_q == ST_ARB) | accept) & (|elig);
  assign grant_idx = rr_pick(elig, ptr_q);

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk_dram_ctrl or posedge rst_dram_ctrl) begin
    if (rst_dram_ctrl) begin
      state_q     <= ST_ARB;
      ptr_q       <= '0;
      held_idx_q  <= '0;
      mem_en_q    <= 1'b0;
      cmd_q       <= CMD_READ;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      if (grant) begin
        state_q     <= ST_ISSUE;
        mem_en_q    <= 1'b1;
        ptr_q       <= grant_idx;
        held_idx_q  <= grant_idx;
        cmd_q       <= req_write[grant_idx] ? CMD_WRITE : CMD_READ;
        mem_addr_q  <= req_addr[grant_idx];
        mem_wdata_q <= req_wdata[grant_idx];
      end else begin
        case (state_q)
          ST_ISSUE: begin
            if (accept) begin
              state_q  <= ST_ARB;
              mem_en_q <= 1'b0;
            end
          end
          default: begin
            state_q  <= ST_ARB;
            mem_en_q <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_dram_ctrl or posedge rst_dram_ctrl) begin
    if (rst_dram_ctrl) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      if (mem_rd_valid) begin
        if (tag_empty) begin
          err_q <= 1'b1;
        end else begin
          rsp_valid_q[tag_head] <= 1'b1;
          rsp_data_q            <= mem_rd_data;
        end
      end
    end
  end

  dram_tag_fifo #(
    .DEPTH (MAX_RD_OUT)
  ) u_tag_fifo (
    .clk_i       (clk_dram_ctrl),
    .rst_i       (rst_dram_ctrl),
    .push_i      (accept & ~mem_write),
    .push_data_i (held_idx_q),
    .pop_i       (mem_rd_valid),
    .head_o      (tag_head),
    .count_o     (rd_outstanding),
    .empty_o     (tag_empty),
    .full_o      (tag_full)
  );

endmodule

// File: tb/tb_dram_request_arbiter.sv
module tb_dram_request_arbiter;
  import dram_arb_pkg::*;

  localparam int NR    = 3;
  localparam int AW    = 24;
  localparam int DW    = 128;
  localparam int MAXRD = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                   en;
  logic [NR-1:0]          req_valid, req_write, req_ready, rsp_valid;
  logic [NR-1:0][AW-1:0]  req_addr;
  logic [NR-1:0][DW-1:0]  req_wdata;
  logic [DW-1:0]          rsp_data, mem_wdata, mem_rd_data;
  logic [AW-1:0]          mem_addr;
  logic                   mem_en, mem_write, mem_wren;
  logic                   mem_rdy, mem_wdf_rdy, mem_rd_valid;
  logic [4:0]             rd_outstanding;
  logic                   err_orphan_rd;
  arb_state_t             dbg_state;

  dram_request_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MAX_RD_OUT(MAXRD)
  ) dut (
    .clk_dram_ctrl  (clk),
    .rst_dram_ctrl  (rst),
    .en             (en),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .mem_addr       (mem_addr),
    .mem_en         (mem_en),
    .mem_write      (mem_write),
    .mem_wdata      (mem_wdata),
    .mem_wren       (mem_wren),
    .mem_rdy        (mem_rdy),
    .mem_wdf_rdy    (mem_wdf_rdy),
    .mem_rd_data    (mem_rd_data),
    .mem_rd_valid   (mem_rd_valid),
    .rd_outstanding (rd_outstanding),
    .err_orphan_rd  (err_orphan_rd),
    .dbg_state      (dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction-level view: one held command (or none), a round-robin
  // pointer, and a queue of owners of reads the controller has taken.
  bit              m_busy;
  int              m_idx;
  bit              m_write;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  int              m_ptr;
  logic [1:0]      exp_q[$];
  bit              m_err;
  logic [NR-1:0]   m_rsp;
  logic [DW-1:0]   m_rsp_data;

  int dut_grants[$];
  int dut_rsp[$];
  int max_out;

  function automatic int last_grant();
    return (dut_grants.size() > 0) ? dut_grants[$] : -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_idx = 0; m_write = 0; m_addr = '0; m_wdata = '0; m_ptr = 0;
    exp_q.delete(); m_err = 0; m_rsp = '0; m_rsp_data = '0;
    dut_grants.delete(); dut_rsp.delete(); max_out = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    mem_rdy = 1'b0; mem_wdf_rdy = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One clock cycle: inputs were set after the previous edge; compare at the
  // falling edge, advance the model, and return just after the rising edge.
  task automatic step();
    int pick, hold_rd, i;
    bit acc;
    logic [NR-1:0] exp_ready;
    @(negedge clk);
    check("mem_en", mem_en, m_busy);
    check("mem_wren", mem_wren, m_busy & m_write);
    check("dbg_state", dbg_state, m_busy);
    if (m_busy) begin
      check("mem_addr", mem_addr, m_addr);
      check("mem_write", mem_write, m_write);
      check("mem_wdata", mem_wdata, m_wdata);
    end
    check("rsp_valid", rsp_valid, m_rsp);
    if (m_rsp != '0) check("rsp_data", rsp_data, m_rsp_data);
    check("rd_outstanding", rd_outstanding, exp_q.size());
    check("err_orphan_rd", err_orphan_rd, m_err);
    if (int'(rd_outstanding) > max_out) max_out = int'(rd_outstanding);
    for (int k = 0; k < NR; k++) begin
      if (req_ready[k]) dut_grants.push_back(k);
      if (rsp_valid[k]) dut_rsp.push_back(k);
    end

    acc     = m_busy && mem_rdy && (!m_write || mem_wdf_rdy);
    hold_rd = (m_busy && !m_write) ? 1 : 0;
    pick    = -1;
    if (!m_busy || acc) begin
      for (int k = 1; k <= NR; k++) begin
        i = (m_ptr + k) % NR;
        if (pick < 0 && req_valid[i] && en && (req_write[i] || (exp_q.size() + hold_rd < MAXRD)))
          pick = i;
      end
    end
    exp_ready = '0;
    if (pick >= 0) exp_ready[pick] = 1'b1;
    check("req_ready", req_ready, exp_ready);

    m_rsp = '0;
    if (mem_rd_valid) begin
      if (exp_q.size() == 0) m_err = 1;
      else begin
        m_rsp[exp_q.pop_front()] = 1'b1;
        m_rsp_data = mem_rd_data;
      end
    end
    if (acc && !m_write) exp_q.push_back(2'(m_idx));
    if (pick >= 0) begin
      m_busy = 1; m_idx = pick; m_ptr = pick;
      m_write = req_write[pick]; m_addr = req_addr[pick]; m_wdata = req_wdata[pick];
    end else if (acc) begin
      m_busy = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && exp_q.size() > 0; n++) begin
      mem_rd_valid = 1'b1;
      mem_rd_data = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    mem_rd_valid = 1'b0;
    step();
    check("drain_empty", rd_outstanding, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_wren", mem_wren, 0);
    check("rst_rd_out", rd_outstanding, 0);
    check("rst_err", err_orphan_rd, 0);

    // single read from client 1
    en = 1; mem_rdy = 1; mem_wdf_rdy = 1;
    req_valid = 3'b010; req_write = 3'b000; req_addr[1] = 24'h000123;
    step();
    check("t1_grant", last_grant(), 1);
    req_valid = '0;
    check("t1_mem_en", mem_en, 1);
    check("t1_mem_addr", mem_addr, 24'h000123);
    step();
    check("t1_en_one_cycle", mem_en, 0);
    repeat (3) step();
    mem_rd_valid = 1; mem_rd_data = {16{8'hA5}};
    step();
    mem_rd_valid = 0;
    check("t1_rsp_valid", rsp_valid, 3'b010);
    check("t1_rsp_data", rsp_data, {16{8'hA5}});
    step();

    // three writers, both ready: rotation 1,2,0 at one command per cycle
    do_reset();
    en = 1; mem_rdy = 1; mem_wdf_rdy = 1;
    req_valid = 3'b111; req_write = 3'b111;
    for (int c = 0; c < 9; c++) begin
      for (int k = 0; k < NR; k++) begin
        req_addr[k] = AW'($urandom);
        req_wdata[k] = {$urandom, $urandom, $urandom, $urandom};
      end
      step();
    end
    check("t2_ngrants", dut_grants.size(), 9);
    for (int k = 0; k < dut_grants.size() && k < 9; k++)
      check("t2_order", dut_grants[k], (k + 1) % 3);
    req_valid = '0;
    repeat (2) step();

    // write stalled on wdf_rdy
    do_reset();
    en = 1; mem_rdy = 1; mem_wdf_rdy = 0;
    req_valid = 3'b001; req_write = 3'b001; req_addr[0] = 24'h0ABCDE; req_wdata[0] = {4{32'h1234_5678}};
    step();
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      step();
      check("t3_hold_addr", mem_addr, 24'h0ABCDE);
      check("t3_hold_en", mem_en, 1);
    end
    check("t3_one_ready", dut_grants.size(), 1);
    mem_wdf_rdy = 1;
    step();
    check("t3_accepted", mem_en, 0);
    step();

    // read limit: 16 outstanding block reads but not writes
    do_reset();
    en = 1; mem_rdy = 1; mem_wdf_rdy = 1;
    req_valid = 3'b001; req_write = 3'b000;
    for (int c = 0; c < 20; c++) begin
      req_addr[0] = AW'($urandom);
      step();
    end
    check("t4_reads_granted", dut_grants.size(), 16);
    check("t4_rd_out_full", rd_outstanding, 16);
    req_valid[2] = 1; req_write[2] = 1; req_addr[2] = 24'h00BEEF;
    step();
    req_valid[2] = 0;
    check("t4_write_grant", last_grant(), 2);
    step();
    mem_rd_valid = 1; mem_rd_data = {$urandom, $urandom, $urandom, $urandom};
    step();
    mem_rd_valid = 0;
    step();
    check("t4_17th_grant", dut_grants.size(), 18);
    check("t4_17th_client", last_grant(), 0);
    req_valid = '0;
    step();
    drain();
    check("t4_max_out", max_out <= MAXRD, 1);

    // interleaved reads from 0 and 2 with returns overlapping accepts
    do_reset();
    en = 1; mem_rdy = 1; mem_wdf_rdy = 1;
    req_valid = 3'b101; req_write = 3'b000;
    for (int c = 0; c < 12; c++) begin
      mem_rd_valid = (c >= 3);
      mem_rd_data = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    req_valid = '0;
    mem_rd_valid = 0;
    step();
    drain();
    check("t5_nrsp", dut_rsp.size(), 12);
    for (int k = 0; k < dut_rsp.size(); k++)
      check("t5_route", dut_rsp[k], (k % 2 == 0) ? 2 : 0);

    // orphan return and reset while a command is held
    do_reset();
    mem_rd_valid = 1; mem_rd_data = {4{32'hDEAD_BEEF}};
    step();
    mem_rd_valid = 0;
    check("t6_orphan", err_orphan_rd, 1);
    check("t6_no_rsp", rsp_valid, 0);
    repeat (3) step();
    check("t6_sticky", err_orphan_rd, 1);
    en = 1; mem_rdy = 1; req_valid = 3'b001; req_write = 3'b000;
    step();
    step();
    mem_rdy = 0;
    step();
    check("t6_busy", mem_en, 1);
    check("t6_out_before", rd_outstanding, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_mem_en", mem_en, 0);
    check("t6_rst_rd_out", rd_outstanding, 0);
    check("t6_rst_err", err_orphan_rd, 0);
    check("t6_rst_state", dbg_state, ST_ARB);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      en = ($urandom_range(0, 15) != 0);
      req_valid = NR'($urandom);
      req_write = NR'($urandom);
      for (int k = 0; k < NR; k++) begin
        req_addr[k] = AW'($urandom);
        req_wdata[k] = {$urandom, $urandom, $urandom, $urandom};
      end
      mem_rdy = ($urandom_range(0, 3) != 0);
      mem_wdf_rdy = ($urandom_range(0, 3) != 0);
      mem_rd_valid = (exp_q.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 49) == 0);
      mem_rd_data = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    req_valid = '0;
    mem_rdy = 1; mem_wdf_rdy = 1;
    step();
    step();
    drain();
    check("rand_max_out", max_out <= MAXRD, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
